// File: rtl/axi_pkg.sv
// Shared AXI bus widths, encodings and the burst-master FSM state type.
// Bus-width macros are defined here once and reused by every AXI block.
`ifndef AXI_DEFINES_DONE
`define AXI_DEFINES_DONE
`define AXI_ID_BITS    4
`define AXI_ADDR_BITS  32
`define AXI_LEN_BITS   4
`define AXI_SIZE_BITS  3
`define AXI_DATA_BITS  32
`define AXI_STRB_BITS  4
`define AXI_SIZE_WORD  3'b010
`define AXI_BURST_INC  2'b01
`endif

package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = `AXI_BURST_INC;
    localparam logic [`AXI_SIZE_BITS-1:0] SIZE_WORD = `AXI_SIZE_WORD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } axi_mst_state_t;

    // True when a word burst starting at this page offset runs past the 4 KB page.
    function automatic logic crosses_4k(input logic [11:0] offs, input logic [3:0] len);
        logic [12:0] end_b;
        end_b = {1'b0, offs} + (({9'b0, len} + 13'd1) << 2);
        return end_b > 13'd4096;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 manager: one INCR word burst per local request, one transaction in flight.
// Define AXI_MASTER_4K_CHECK_EN to reject bursts that cross a 4 KB page.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [31:0]                 req_addr,
    input  logic [3:0]                  req_len,
    input  logic                        wd_valid,
    output logic                        wd_ready,
    input  logic [31:0]                 wd_data,
    input  logic [3:0]                  wd_strb,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [31:0]                 rd_data,
    output logic                        rd_last,
    output logic                        done,
    output logic                        err,
    output logic [`AXI_ID_BITS-1:0]     ARID,
    output logic [`AXI_ADDR_BITS-1:0]   ARADDR,
    output logic [`AXI_LEN_BITS-1:0]    ARLEN,
    output logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
    output logic [1:0]                  ARBURST,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    input  logic [`AXI_ID_BITS-1:0]     RID,
    input  logic [`AXI_DATA_BITS-1:0]   RDATA,
    input  logic [1:0]                  RRESP,
    input  logic                        RLAST,
    input  logic                        RVALID,
    output logic                        RREADY,
    output logic [`AXI_ID_BITS-1:0]     AWID,
    output logic [`AXI_ADDR_BITS-1:0]   AWADDR,
    output logic [`AXI_LEN_BITS-1:0]    AWLEN,
    output logic [`AXI_SIZE_BITS-1:0]   AWSIZE,
    output logic [1:0]                  AWBURST,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [`AXI_DATA_BITS-1:0]   WDATA,
    output logic [`AXI_STRB_BITS-1:0]   WSTRB,
    output logic                        WLAST,
    output logic                        WVALID,
    input  logic                        WREADY,
    input  logic [`AXI_ID_BITS-1:0]     BID,
    input  logic [1:0]                  BRESP,
    input  logic                        BVALID,
    output logic                        BREADY
);

    axi_mst_state_t state, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d, cnt, cnt_d;
    logic        racc, racc_d, done_q, done_d, err_q, err_d, beat_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            racc   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            addr_q <= addr_d;
            len_q  <= len_d;
            cnt    <= cnt_d;
            racc   <= racc_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign done    = done_q;
    assign err     = err_q;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;

    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt;
        racc_d    = racc;
        done_d    = 1'b0;
        err_d     = err_q;
        beat_err  = 1'b0;
        req_ready = 1'b0;
        wd_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_last   = 1'b0;
        ARID      = '0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        AWID      = '0;
        AWVALID   = 1'b0;
        WDATA     = '0;
        WSTRB     = '0;
        WLAST     = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        case (state)
            S_IDLE: begin
                // Stay closed during the done cycle so back-to-back requests see a clean gap.
                req_ready = !done_q;
                if (req_valid && !done_q) begin
                    addr_d = req_addr;
                    len_d  = req_len;
                    cnt_d  = '0;
                    racc_d = 1'b0;
`ifdef AXI_MASTER_4K_CHECK_EN
                    if (crosses_4k(req_addr[11:0], req_len)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = req_write ? S_AW : S_AR;
                    end
`else
                    state_d = req_write ? S_AW : S_AR;
`endif
                end
            end
            S_AR: begin
                ARID    = MASTER_ID;
                ARVALID = 1'b1;
                if (ARREADY) state_d = S_R;
            end
            S_R: begin
                RREADY   = rd_ready;
                rd_valid = RVALID;
                rd_data  = RDATA;
                rd_last  = RLAST;
                if (RVALID && rd_ready) begin
                    cnt_d    = cnt + 4'd1;
                    // Early or missing RLAST both flag; extra beats are still drained.
                    beat_err = (RRESP != RESP_OKAY) || (RID != MASTER_ID) ||
                               (RLAST != (cnt == len_q));
                    if (RLAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = racc || beat_err;
                    end else begin
                        racc_d  = racc || beat_err;
                    end
                end
            end
            S_AW: begin
                AWID    = MASTER_ID;
                AWVALID = 1'b1;
                if (AWREADY) state_d = S_W;
            end
            S_W: begin
                WVALID   = wd_valid;
                wd_ready = WREADY;
                WDATA    = wd_data;
                WSTRB    = wd_strb;
                WLAST    = (cnt == len_q);
                if (wd_valid && WREADY) begin
                    cnt_d = cnt + 4'd1;
                    if (cnt == len_q) state_d = S_B;
                end
            end
            S_B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = (BRESP != RESP_OKAY) || (BID != MASTER_ID);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: the bench plays the AXI slave and the local client.
module tb_axi_burst_master;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        req_valid = 0, req_ready, req_write = 0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic        wd_valid = 0, wd_ready;
    logic [31:0] wd_data = '0;
    logic [3:0]  wd_strb = '0;
    logic        rd_valid, rd_ready = 0, rd_last, done, err;
    logic [31:0] rd_data;
    logic [3:0]  ARID, AWID, RID = '0, BID = '0;
    logic [31:0] ARADDR, AWADDR, RDATA = '0, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP = '0, BRESP = '0;
    logic        ARVALID, ARREADY = 0, RLAST = 0, RVALID = 0, RREADY;
    logic        AWVALID, AWREADY = 0, WLAST, WVALID, WREADY = 1, BVALID = 0, BREADY;

    int n_vec = 0, n_err = 0;

    always #5 CLK = ~CLK;

    axi_burst_master dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 ns after the edge; checks run 1 ns after that.
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(); cyc();
        settle();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_bready", BREADY, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_arlen", ARLEN, 0);
        chk("rst_arid", ARID, 0);
        RST = 0;
        cyc();

        // Read len 3, four OKAY beats
        req_valid = 1; req_write = 0; req_addr = 32'h1000_0000; req_len = 3; rd_ready = 1;
        settle();
        chk("rd1_req_ready", req_ready, 1);
        cyc();
        req_valid = 0;
        settle();
        chk("rd1_arvalid", ARVALID, 1);
        chk("rd1_araddr", ARADDR, 32'h1000_0000);
        chk("rd1_arlen", ARLEN, 3);
        chk("rd1_arburst", ARBURST, 2'b01);
        chk("rd1_arsize", ARSIZE, 3'b010);
        chk("rd1_req_ready_busy", req_ready, 0);
        ARREADY = 1;
        cyc();
        ARREADY = 0;
        for (int i = 0; i < 4; i++) begin
            RVALID = 1; RDATA = 32'hD000_0000 + i; RLAST = (i == 3);
            settle();
            chk("rd1_rd_valid", rd_valid, 1);
            chk("rd1_rd_data", rd_data, 32'hD000_0000 + i);
            chk("rd1_rd_last", rd_last, (i == 3));
            chk("rd1_rready", RREADY, 1);
            chk("rd1_no_early_done", done, 0);
            cyc();
        end
        RVALID = 0; RLAST = 0;
        settle();
        chk("rd1_done", done, 1);
        chk("rd1_err", err, 0);
        chk("rd1_req_ready_done_cycle", req_ready, 0);
        cyc();
        settle();
        chk("rd1_done_pulse", done, 0);
        chk("rd1_req_ready_back", req_ready, 1);

        // Write len 1, AWREADY held off 3 cycles
        req_valid = 1; req_write = 1; req_addr = 32'h2000_0000; req_len = 1;
        wd_valid = 1; wd_data = 32'hA5A5_0001; wd_strb = 4'hF;
        cyc();
        req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("wr1_awvalid_wait", AWVALID, 1);
            chk("wr1_wvalid_before_aw", WVALID, 0);
            chk("wr1_wd_ready_before_aw", wd_ready, 0);
            cyc();
        end
        AWREADY = 1;
        settle();
        chk("wr1_awaddr", AWADDR, 32'h2000_0000);
        chk("wr1_awlen", AWLEN, 1);
        cyc();
        AWREADY = 0;
        settle();
        chk("wr1_wvalid_b0", WVALID, 1);
        chk("wr1_wdata_b0", WDATA, 32'hA5A5_0001);
        chk("wr1_wlast_b0", WLAST, 0);
        chk("wr1_awvalid_off", AWVALID, 0);
        cyc();
        wd_data = 32'hA5A5_0002;
        settle();
        chk("wr1_wdata_b1", WDATA, 32'hA5A5_0002);
        chk("wr1_wlast_b1", WLAST, 1);
        cyc();
        wd_valid = 0;
        settle();
        chk("wr1_bready", BREADY, 1);
        chk("wr1_wvalid_in_b", WVALID, 0);
        BVALID = 1; BRESP = 2'b00;
        cyc();
        BVALID = 0;
        settle();
        chk("wr1_done", done, 1);
        chk("wr1_err", err, 0);
        cyc();

        // Read len 2, consumer stalls 5 cycles mid-burst
        req_valid = 1; req_write = 0; req_addr = 32'h3000_0000; req_len = 2; ARREADY = 1;
        cyc();
        req_valid = 0;
        cyc();
        ARREADY = 0;
        RVALID = 1; RDATA = 32'h30; rd_ready = 1;
        cyc();
        RDATA = 32'h31; rd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("rd3_rready_stall", RREADY, 0);
            chk("rd3_rd_data_hold", rd_data, 32'h31);
            cyc();
        end
        rd_ready = 1;
        settle();
        chk("rd3_rready_resume", RREADY, 1);
        cyc();
        RDATA = 32'h32; RLAST = 1;
        settle();
        chk("rd3_rd_last", rd_last, 1);
        chk("rd3_no_done_yet", done, 0);
        cyc();
        RVALID = 0; RLAST = 0;
        settle();
        chk("rd3_done", done, 1);
        chk("rd3_err", err, 0);
        cyc();

        // Write len 0 answered with SLVERR
        req_valid = 1; req_write = 1; req_addr = 32'h4000_0000; req_len = 0; AWREADY = 1;
        cyc();
        req_valid = 0;
        cyc();
        AWREADY = 0; wd_valid = 1; wd_data = 32'h5;
        settle();
        chk("wr4_wlast_len0", WLAST, 1);
        cyc();
        wd_valid = 0; BVALID = 1; BRESP = 2'b10;
        cyc();
        BVALID = 0; BRESP = 2'b00;
        settle();
        chk("wr4_done", done, 1);
        chk("wr4_err_slverr", err, 1);
        cyc();

        // Read len 3 with RLAST on the second beat
        req_valid = 1; req_write = 0; req_addr = 32'h5000_0000; req_len = 3; ARREADY = 1;
        cyc();
        req_valid = 0;
        cyc();
        ARREADY = 0; RVALID = 1; RDATA = 32'h50;
        cyc();
        RDATA = 32'h51; RLAST = 1;
        cyc();
        RVALID = 0; RLAST = 0;
        settle();
        chk("rd4_done_early_last", done, 1);
        chk("rd4_err_early_last", err, 1);
        cyc();
        settle();
        chk("rd4_err_holds", err, 1);
        chk("rd4_done_low", done, 0);

        // Write len 15: WLAST only on the 16th beat
        req_valid = 1; req_write = 1; req_addr = 32'h6000_0000; req_len = 15; AWREADY = 1;
        cyc();
        req_valid = 0;
        cyc();
        AWREADY = 0; wd_valid = 1;
        for (int i = 0; i < 16; i++) begin
            wd_data = 32'h6000 + i;
            settle();
            chk("wr15_wlast", WLAST, (i == 15));
            cyc();
        end
        wd_valid = 0;
        settle();
        chk("wr15_in_b", BREADY, 1);
        BVALID = 1;
        cyc();
        BVALID = 0;
        settle();
        chk("wr15_done", done, 1);
        chk("wr15_err", err, 0);
        cyc();

        // Reset in W after one of four beats
        req_valid = 1; req_write = 1; req_addr = 32'h7000_0000; req_len = 3; AWREADY = 1;
        cyc();
        req_valid = 0;
        cyc();
        AWREADY = 0; wd_valid = 1;
        cyc();
        settle();
        chk("rst_mid_wvalid_before", WVALID, 1);
        RST = 1;
        cyc();
        RST = 0;
        settle();
        chk("rst_mid_wvalid", WVALID, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_awvalid", AWVALID, 0);
        wd_valid = 0;
        req_valid = 1; req_write = 0; req_addr = 32'h0000_0040; req_len = 0; ARREADY = 1;
        cyc();
        req_valid = 0;
        settle();
        chk("rst_rd_arvalid", ARVALID, 1);
        cyc();
        ARREADY = 0; RVALID = 1; RDATA = 32'h77; RLAST = 1;
        settle();
        chk("rst_rd_data", rd_data, 32'h77);
        cyc();
        RVALID = 0; RLAST = 0;
        settle();
        chk("rst_rd_done", done, 1);
        chk("rst_rd_err", err, 0);
        cyc();

        // Request crossing a 4 KB page
        req_valid = 1; req_write = 0; req_addr = 32'h0000_0FF8; req_len = 3;
        cyc();
        req_valid = 0;
        settle();
`ifdef AXI_MASTER_4K_CHECK_EN
        chk("4k_arvalid", ARVALID, 0);
        chk("4k_done", done, 1);
        chk("4k_err", err, 1);
        cyc();
        settle();
        chk("4k_arvalid_later", ARVALID, 0);
        chk("4k_req_ready", req_ready, 1);
`else
        chk("4k_arvalid_issued", ARVALID, 1);
        chk("4k_araddr", ARADDR, 32'h0000_0FF8);
        chk("4k_no_done", done, 0);
        ARREADY = 1;
        cyc();
        ARREADY = 0;
        for (int i = 0; i < 4; i++) begin
            RVALID = 1; RDATA = 32'h8000 + i; RLAST = (i == 3);
            cyc();
        end
        RVALID = 0; RLAST = 0;
        settle();
        chk("4k_done", done, 1);
        chk("4k_err", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
